axi_r_xbar_rr: RTL and testbench

- Parametrised AXI read-data (R) channel crossbar: NUM_S slave R channels (last index = default slave) to NUM_M master R channels.
- Arbitration: round-robin with burst lock. A granted slave keeps the channel until its RLAST beat handshakes.
- Routing: the master is selected from the upper (master-tag) bits of the slave-side RID; the lower ID_W bits are returned to the master.
- Next-generation R channel of the interconnect. Replaces fixed 3-slave/2-master fixed-priority routing with fair, parametrised arbitration.

---
 rtl/axi_xbar_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/axi_r_xbar_rr.sv | 142 ++++++++++++++
 tb/tb_axi_r_xbar_rr.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared types and helpers for the AXI crossbar channel blocks.
// Used by the R-channel crossbar and its round-robin arbiter.
package axi_xbar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } xbar_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Index width that stays at least one bit for a single requester.
  function automatic int s_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ids_w(input int mtag_w, input int id_w);
    return mtag_w + id_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search over N requesters.
// The lowest offset from ptr (with wrap) wins.
module rr_arbiter
  import axi_xbar_pkg::*;
#(
  parameter  int N = 3,
  localparam int W = s_idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  int idx;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    // Walk from the far end so the nearest request overwrites last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_idx   = W'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_r_xbar_rr.sv
// AXI R-channel crossbar: NUM_S slaves to NUM_M masters,
// round-robin with burst lock, routed on the RID master tag.
module axi_r_xbar_rr
  import axi_xbar_pkg::*;
#(
  parameter  int NUM_S  = 3,
  parameter  int NUM_M  = 2,
  parameter  int ID_W   = 4,
  parameter  int MTAG_W = 4,
  parameter  int DATA_W = 32,
  localparam int IDS_W  = ids_w(MTAG_W, ID_W),
  localparam int SW     = s_idx_w(NUM_S)
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [NUM_S*IDS_W-1:0]  RID_S,
  input  logic [NUM_S*DATA_W-1:0] RDATA_S,
  input  logic [NUM_S*2-1:0]      RRESP_S,
  input  logic [NUM_S-1:0]        RLAST_S,
  input  logic [NUM_S-1:0]        RVALID_S,
  output logic [NUM_S-1:0]        RREADY_S,
  input  logic [NUM_M-1:0]        RREADY_M,
  output logic [NUM_M*ID_W-1:0]   RID_M,
  output logic [NUM_M*DATA_W-1:0] RDATA_M,
  output logic [NUM_M*2-1:0]      RRESP_M,
  output logic [NUM_M-1:0]        RLAST_M,
  output logic [NUM_M-1:0]        RVALID_M,
  output logic                    BUSY
);

  xbar_state_e state, state_n;

  logic [SW-1:0]     gnt, gnt_n;
  logic [SW-1:0]     rr_ptr, rr_ptr_n;
  logic [SW-1:0]     gnt_c, arb_idx;
  logic              arb_valid, gnt_v;
  logic              vld, last, legal;
  logic              route_ready, hs;
  logic [IDS_W-1:0]  rid;
  logic [MTAG_W-1:0] mtag;
  logic [DATA_W-1:0] data;
  logic [1:0]        resp;
  logic [NUM_M-1:0]  vm;

  function automatic logic [SW-1:0] ptr_inc(
    input logic [SW-1:0] p
  );
    return (p == SW'(NUM_S - 1)) ? '0 : p + SW'(1);
  endfunction

  rr_arbiter #(
    .N(NUM_S)
  ) u_arb (
    .req      (RVALID_S),
    .ptr      (rr_ptr),
    .gnt_idx  (arb_idx),
    .gnt_valid(arb_valid)
  );

  // Grant source and payload mux.
  always_comb begin
    gnt_c = (state == BURST) ? gnt : arb_idx;
    gnt_v = (state == BURST) || arb_valid;
    rid   = '0;
    data  = '0;
    resp  = RESP_OKAY;
    last  = 1'b0;
    vld   = 1'b0;
    for (int i = 0; i < NUM_S; i++) begin
      if (gnt_c == SW'(i)) begin
        rid  = RID_S[i*IDS_W +: IDS_W];
        data = RDATA_S[i*DATA_W +: DATA_W];
        resp = RRESP_S[i*2 +: 2];
        last = RLAST_S[i];
        vld  = gnt_v & RVALID_S[i];
      end
    end
  end

  // Steering; an unknown tag drains the beat with no master valid.
  always_comb begin
    mtag        = rid[IDS_W-1 -: MTAG_W];
    legal       = int'(mtag) < NUM_M;
    route_ready = !legal;
    vm          = '0;
    for (int m = 0; m < NUM_M; m++) begin
      if (legal && mtag == MTAG_W'(m)) begin
        vm[m]       = vld;
        route_ready = RREADY_M[m];
      end
    end
    hs = vld & route_ready;
    for (int i = 0; i < NUM_S; i++) begin
      RREADY_S[i] = hs && (gnt_c == SW'(i));
    end
  end

  assign RID_M    = {NUM_M{rid[ID_W-1:0]}};
  assign RDATA_M  = {NUM_M{data}};
  assign RRESP_M  = {NUM_M{resp}};
  assign RLAST_M  = {NUM_M{last}};
  assign RVALID_M = vm;
  assign BUSY     = (state == BURST);

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    rr_ptr_n = rr_ptr;
    unique case (state)
      IDLE: begin
        if (vld) begin
          if (hs && last) begin
            rr_ptr_n = ptr_inc(gnt_c);
          end else begin
            state_n = BURST;
            gnt_n   = gnt_c;
          end
        end
      end
      BURST: begin
        if (hs && last) begin
          state_n  = IDLE;
          rr_ptr_n = ptr_inc(gnt);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      rr_ptr <= rr_ptr_n;
    end
  end

endmodule

// File: tb/tb_axi_r_xbar_rr.sv
// Bench for axi_r_xbar_rr: directed scenarios plus a randomized
// run against a burst-level arbitration model.
module tb_axi_r_xbar_rr;

  localparam int NUM_S  = 3;
  localparam int NUM_M  = 2;
  localparam int ID_W   = 4;
  localparam int MTAG_W = 4;
  localparam int DATA_W = 32;
  localparam int IDS_W  = MTAG_W + ID_W;

  logic                    ACLK;
  logic                    ARESETn;
  logic [NUM_S*IDS_W-1:0]  RID_S;
  logic [NUM_S*DATA_W-1:0] RDATA_S;
  logic [NUM_S*2-1:0]      RRESP_S;
  logic [NUM_S-1:0]        RLAST_S;
  logic [NUM_S-1:0]        RVALID_S;
  logic [NUM_S-1:0]        RREADY_S;
  logic [NUM_M-1:0]        RREADY_M;
  logic [NUM_M*ID_W-1:0]   RID_M;
  logic [NUM_M*DATA_W-1:0] RDATA_M;
  logic [NUM_M*2-1:0]      RRESP_M;
  logic [NUM_M-1:0]        RLAST_M;
  logic [NUM_M-1:0]        RVALID_M;
  logic                    BUSY;

  int n_cmp = 0;
  int n_err = 0;

  axi_r_xbar_rr #(
    .NUM_S (NUM_S),
    .NUM_M (NUM_M),
    .ID_W  (ID_W),
    .MTAG_W(MTAG_W),
    .DATA_W(DATA_W)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .RID_S   (RID_S),
    .RDATA_S (RDATA_S),
    .RRESP_S (RRESP_S),
    .RLAST_S (RLAST_S),
    .RVALID_S(RVALID_S),
    .RREADY_S(RREADY_S),
    .RREADY_M(RREADY_M),
    .RID_M   (RID_M),
    .RDATA_M (RDATA_M),
    .RRESP_M (RRESP_M),
    .RLAST_M (RLAST_M),
    .RVALID_M(RVALID_M),
    .BUSY    (BUSY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_idle();
    RVALID_S = '0;
    RLAST_S  = '0;
    RID_S    = '0;
    RDATA_S  = '0;
    RRESP_S  = '0;
    RREADY_M = '1;
  endtask

  task automatic set_s(input int i, input logic v,
                       input logic [IDS_W-1:0] id,
                       input logic [DATA_W-1:0] d,
                       input logic l);
    RVALID_S[i]              = v;
    RID_S[i*IDS_W +: IDS_W]  = id;
    RDATA_S[i*DATA_W +: DATA_W] = d;
    RRESP_S[i*2 +: 2]        = 2'(i);
    RLAST_S[i]               = l;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    drive_idle();
    tick();
    ARESETn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (RVALID_M !== 2'b00) begin
      n_err++; $display("FAIL reset_vm got %b want 00", RVALID_M);
    end
    n_cmp++;
    if (RREADY_S !== 3'b000) begin
      n_err++; $display("FAIL reset_rs got %b want 000", RREADY_S);
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got %b want 0", BUSY);
    end
  endtask

  task automatic test_single();
    set_s(0, 1'b1, 8'h03, 32'h0000_00A0, 1'b1);
    #1;
    n_cmp++;
    if (RVALID_M !== 2'b01) begin
      n_err++; $display("FAIL single_vm got %b want 01", RVALID_M);
    end
    n_cmp++;
    if (RID_M[3:0] !== 4'h3) begin
      n_err++; $display("FAIL single_id got %h want 3", RID_M[3:0]);
    end
    n_cmp++;
    if (RREADY_S !== 3'b001) begin
      n_err++; $display("FAIL single_rs got %b want 001", RREADY_S);
    end
    n_cmp++;
    if (RDATA_M[31:0] !== 32'hA0) begin
      n_err++; $display("FAIL single_data got %h want a0", RDATA_M[31:0]);
    end
    tick();
    // Pointer moved to 1: slave 1 now wins over slave 0.
    set_s(1, 1'b1, 8'h01, 32'h0000_00A1, 1'b1);
    #1;
    n_cmp++;
    if (RREADY_S !== 3'b010) begin
      n_err++; $display("FAIL single_ptr got %b want 010", RREADY_S);
    end
  endtask

  task automatic test_contention();
    logic [NUM_S-1:0] ers;
    logic [NUM_M-1:0] evm;
    do_reset();
    set_s(0, 1'b1, 8'h01, 32'hC0, 1'b1);
    set_s(1, 1'b1, 8'h12, 32'hC1, 1'b1);
    set_s(2, 1'b1, 8'h03, 32'hC2, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #1;
      ers = 3'(1 << (c % 3));
      evm = (c % 3 == 1) ? 2'b10 : 2'b01;
      n_cmp++;
      if (RREADY_S !== ers) begin
        n_err++;
        $display("FAIL cont_rs[%0d] got %b want %b", c, RREADY_S, ers);
      end
      n_cmp++;
      if (RVALID_M !== evm) begin
        n_err++;
        $display("FAIL cont_vm[%0d] got %b want %b", c, RVALID_M, evm);
      end
      tick();
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    set_s(0, 1'b1, 8'h00, 32'hD0, 1'b1);
    #1;
    tick();
    for (int b = 0; b < 4; b++) begin
      set_s(1, 1'b1, 8'h12, 32'hE0 + b, b == 3);
      #1;
      n_cmp++;
      if (RREADY_S !== 3'b010) begin
        n_err++;
        $display("FAIL lock_rs[%0d] got %b want 010", b, RREADY_S);
      end
      n_cmp++;
      if (RVALID_M !== 2'b10) begin
        n_err++;
        $display("FAIL lock_vm[%0d] got %b want 10", b, RVALID_M);
      end
      if (b > 0) begin
        n_cmp++;
        if (BUSY !== 1'b1) begin
          n_err++;
          $display("FAIL lock_busy[%0d] got %b want 1", b, BUSY);
        end
      end
      tick();
    end
    set_s(1, 1'b0, 8'h12, 32'h0, 1'b0);
    #1;
    n_cmp++;
    if (RREADY_S !== 3'b001) begin
      n_err++; $display("FAIL lock_next got %b want 001", RREADY_S);
    end
  endtask

  task automatic test_backpressure();
    int b;
    int stall;
    int seen;
    do_reset();
    b = 0;
    stall = 0;
    seen = 0;
    for (int cyc = 0; cyc < 20 && b < 4; cyc++) begin
      set_s(0, 1'b1, 8'h05, 32'hB000 + b, b == 3);
      RREADY_M[0] = !(b == 1 && stall < 3);
      #1;
      if (RREADY_S[0] === 1'b1) seen++;
      if (!RREADY_M[0]) begin
        stall++;
        n_cmp++;
        if (RVALID_M[0] !== 1'b1 || RDATA_M[31:0] !== 32'hB001) begin
          n_err++;
          $display("FAIL bp_hold got vm=%b d=%h want 1 b001",
                   RVALID_M[0], RDATA_M[31:0]);
        end
        n_cmp++;
        if (RREADY_S !== 3'b000 || BUSY !== 1'b1) begin
          n_err++;
          $display("FAIL bp_stall got rs=%b busy=%b want 000 1",
                   RREADY_S, BUSY);
        end
      end else begin
        n_cmp++;
        if (RREADY_S !== 3'b001) begin
          n_err++;
          $display("FAIL bp_beat[%0d] got %b want 001", b, RREADY_S);
        end
        b++;
      end
      tick();
    end
    RREADY_M = '1;
    set_s(0, 1'b0, 8'h05, 32'h0, 1'b0);
    #1;
    n_cmp++;
    if (seen !== 4) begin
      n_err++; $display("FAIL bp_beats got %0d want 4", seen);
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL bp_end_busy got %b want 0", BUSY);
    end
  endtask

  task automatic test_illegal_tag();
    do_reset();
    for (int b = 0; b < 2; b++) begin
      set_s(2, 1'b1, {4'd5, 4'h7}, 32'hF0 + b, b == 1);
      #1;
      n_cmp++;
      if (RVALID_M !== 2'b00 || RREADY_S !== 3'b100) begin
        n_err++;
        $display("FAIL ill_beat[%0d] got vm=%b rs=%b want 00 100",
                 b, RVALID_M, RREADY_S);
      end
      tick();
      if (b == 0) begin
        n_cmp++;
        if (BUSY !== 1'b1) begin
          n_err++; $display("FAIL ill_busy got %b want 1", BUSY);
        end
      end
    end
    set_s(2, 1'b0, 8'h00, 32'h0, 1'b0);
    #1;
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL ill_done got %b want 0", BUSY);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_s(0, 1'b1, 8'h00, 32'h10, 1'b1);
    #1;
    tick();
    set_s(0, 1'b0, 8'h00, 32'h0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      set_s(1, 1'b1, 8'h1A, 32'h20 + b, 1'b0);
      if (b == 2) ARESETn = 1'b0;
      #1;
      tick();
    end
    ARESETn = 1'b1;
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_busy got %b want 0", BUSY);
    end
    set_s(1, 1'b0, 8'h1A, 32'h0, 1'b0);
    set_s(0, 1'b1, 8'h00, 32'h30, 1'b1);
    set_s(2, 1'b1, 8'h14, 32'h32, 1'b1);
    #1;
    n_cmp++;
    if (RREADY_S !== 3'b001) begin
      n_err++; $display("FAIL rst_mid_ptr got %b want 001", RREADY_S);
    end
    set_s(0, 1'b0, 8'h00, 32'h0, 1'b0);
    #1;
    n_cmp++;
    if (RREADY_S !== 3'b100 || RVALID_M !== 2'b10) begin
      n_err++;
      $display("FAIL rst_mid_s2 got rs=%b vm=%b want 100 10",
               RREADY_S, RVALID_M);
    end
    tick();
  endtask

  task automatic test_random();
    int                s_left [NUM_S];
    bit                s_vld  [NUM_S];
    logic [IDS_W-1:0]  s_id   [NUM_S];
    logic [DATA_W-1:0] s_data [NUM_S];
    int                owner;
    int                ptr;
    int                g;
    int                idx;
    int                tag;
    bit                hs;
    bit                lst;
    logic [NUM_M-1:0]  evm;
    logic [NUM_S-1:0]  ers;
    do_reset();
    owner = -1;
    ptr = 0;
    for (int i = 0; i < NUM_S; i++) begin
      s_left[i] = 0;
      s_vld[i] = 1'b0;
      s_id[i] = '0;
      s_data[i] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NUM_S; i++) begin
        if (!s_vld[i]) begin
          if (s_left[i] == 0) begin
            s_left[i] = $urandom_range(1, 4);
            tag = ($urandom % 8 == 0) ? 5 : int'($urandom % NUM_M);
            s_id[i] = {4'(tag), 4'($urandom)};
          end
          if ($urandom % 10 < 6) begin
            s_vld[i] = 1'b1;
            s_data[i] = $urandom;
          end
        end
        set_s(i, s_vld[i], s_id[i], s_data[i], s_left[i] == 1);
      end
      RREADY_M = NUM_M'($urandom);
      #1;
      // Owner holds the channel; otherwise nearest requester from ptr.
      g = owner;
      if (g < 0) begin
        for (int k = 0; k < NUM_S; k++) begin
          idx = (ptr + k) % NUM_S;
          if (g < 0 && s_vld[idx]) g = idx;
        end
      end
      evm = '0;
      ers = '0;
      hs = 1'b0;
      lst = 1'b0;
      if (g >= 0 && s_vld[g]) begin
        tag = int'(s_id[g][IDS_W-1 -: MTAG_W]);
        lst = (s_left[g] == 1);
        if (tag < NUM_M) begin
          evm[tag] = 1'b1;
          hs = RREADY_M[tag];
        end else begin
          hs = 1'b1;
        end
        if (hs) ers[g] = 1'b1;
        n_cmp++;
        if (RDATA_M !== {NUM_M{s_data[g]}} ||
            RID_M !== {NUM_M{s_id[g][ID_W-1:0]}} ||
            RLAST_M !== {NUM_M{lst}}) begin
          n_err++;
          $display("FAIL rnd_payload[%0d] got d=%h id=%h l=%b want %h %h %b",
                   cyc, RDATA_M[31:0], RID_M[3:0], RLAST_M,
                   s_data[g], s_id[g][ID_W-1:0], lst);
        end
      end
      n_cmp++;
      if (RVALID_M !== evm) begin
        n_err++;
        $display("FAIL rnd_vm[%0d] got %b want %b", cyc, RVALID_M, evm);
      end
      n_cmp++;
      if (RREADY_S !== ers) begin
        n_err++;
        $display("FAIL rnd_rs[%0d] got %b want %b", cyc, RREADY_S, ers);
      end
      n_cmp++;
      if (BUSY !== (owner >= 0)) begin
        n_err++;
        $display("FAIL rnd_busy[%0d] got %b want %b", cyc, BUSY, owner >= 0);
      end
      tick();
      if (hs) begin
        s_vld[g] = 1'b0;
        s_left[g]--;
        if (lst) begin
          owner = -1;
          ptr = (g + 1) % NUM_S;
        end else begin
          owner = g;
        end
      end else if (g >= 0 && s_vld[g]) begin
        owner = g;
      end
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    drive_idle();
    test_reset();
    test_single();
    test_contention();
    test_burst_lock();
    test_backpressure();
    test_illegal_tag();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
